// File: rtl/box_probe.sv
// Sweeps a square box of framebuffer coordinates through the memory read port
// and reports whether any on-screen pixel differs from the background colour.
module box_probe #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  givex,
  input  logic [6:0]  givey,
  input  logic [4:0]  size,
  input  logic [2:0]  bg_colour,
  output logic [14:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [2:0]  mem_rd_data,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [8:0]  hit_count,
  output logic [7:0]  first_hit_x,
  output logic [6:0]  first_hit_y
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  localparam logic [8:0]  X_LIM  = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIM  = 8'(SCREEN_H);
  localparam logic [14:0] STRIDE = 15'(SCREEN_W);

  state_e      state_q, state_d;
  logic [8:0]  cx_q, cx_d;
  logic [7:0]  cy_q, cy_d;
  logic [7:0]  x0_q, x0_d;
  logic [8:0]  x_end_q, x_end_d;
  logic [7:0]  y_end_q, y_end_d;
  logic [2:0]  bg_q, bg_d;
  logic [14:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [7:0]  px_q, px_d;
  logic [6:0]  py_q, py_d;
  logic        hit_q, hit_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  fx_q, fx_d;
  logic [6:0]  fy_q, fy_d;

  logic        on_screen;
  logic [14:0] addr_cur;
  logic [4:0]  size_eff;

  // Coordinates are kept one bit wider than the screen so off-screen pixels never alias.
  assign on_screen = (cx_q < X_LIM) && (cy_q < Y_LIM);
  assign addr_cur  = {7'b0, cy_q} * STRIDE + {6'b0, cx_q};
  assign size_eff  = (size > 5'd16) ? 5'd16 : size;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    bg_d    = bg_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    px_d    = cx_q[7:0];
    py_d    = cy_q[6:0];
    hit_d   = hit_q;
    count_d = count_q;
    fx_d    = fx_q;
    fy_d    = fy_q;

    // Compare stage: judges the pixel whose read was issued last cycle.
    if (valid_q && (mem_rd_data != bg_q)) begin
      count_d = count_q + 9'd1;
      if (!hit_q) begin
        hit_d = 1'b1;
        fx_d  = px_q;
        fy_d  = py_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = givex;
          cx_d    = {1'b0, givex};
          cy_d    = {1'b0, givey};
          x_end_d = {1'b0, givex} + {4'b0, size_eff} - 9'd1;
          y_end_d = {1'b0, givey} + {3'b0, size_eff} - 8'd1;
          bg_d    = bg_colour;
          hit_d   = 1'b0;
          count_d = 9'd0;
          fx_d    = 8'd0;
          fy_d    = 7'd0;
          state_d = (size_eff == 5'd0) ? DRAIN : SCAN;
        end
      end
      SCAN: begin
        valid_d = on_screen;
        addr_d  = addr_cur;
        if (cx_q == x_end_q) begin
          cx_d = {1'b0, x0_q};
          if (cy_q == y_end_q) begin
            state_d = DRAIN;
          end else begin
            cy_d = cy_q + 8'd1;
          end
        end else begin
          cx_d = cx_q + 9'd1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= 9'd0;
      cy_q    <= 8'd0;
      x0_q    <= 8'd0;
      x_end_q <= 9'd0;
      y_end_q <= 8'd0;
      bg_q    <= 3'd0;
      addr_q  <= 15'd0;
      valid_q <= 1'b0;
      px_q    <= 8'd0;
      py_q    <= 7'd0;
      hit_q   <= 1'b0;
      count_q <= 9'd0;
      fx_q    <= 8'd0;
      fy_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      bg_q    <= bg_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hit_q   <= hit_d;
      count_q <= count_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

  // The address is live while scanning and otherwise holds the last one issued.
  assign mem_addr    = (state_q == SCAN) ? addr_cur : addr_q;
  assign mem_rd_en   = (state_q == SCAN) && on_screen;
  assign busy        = (state_q == SCAN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign hit         = hit_q;
  assign hit_count   = count_q;
  assign first_hit_x = fx_q;
  assign first_hit_y = fy_q;

endmodule
